timer_dev: RTL and testbench

Memory-mapped countdown timer that sits on the device side of the CPU/device bridge as DEV0 or DEV1. It answers the bridge's word-address/write-enable/write-data strobes with combinational read data. It raises an interrupt line that the bridge forwards into the CPU's HWInt vector. It supports one-shot and auto-reload modes, with a maskable interrupt.

---
 rtl/timer_dev.sv | 131 +++++++++++++
 tb/tb_timer_dev.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation and a maskable, registered interrupt request.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  ctrl_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic        pend_r;
    logic        irq_r;

    logic        ctrl_wr_s;
    logic        preset_wr_s;
    logic        en_s;
    logic        auto_s;
    logic        expire_s;
    logic        pend_nxt_s;
    logic [3:0]  ctrl_nxt_s;

    assign ctrl_wr_s   = WE && (Addr == 2'd0);
    assign preset_wr_s = WE && (Addr == 2'd1);
    assign en_s        = ctrl_r[0];
    // Modes 10 and 11 fall back to one-shot behaviour.
    assign auto_s      = (ctrl_r[2:1] == 2'b01);
    assign expire_s    = (state_r == S_CNT) && en_s && (count_r <= 32'd1);

    // Pending flag: expiry beats a coincident software clear so no interrupt is lost.
    always_comb begin
        pend_nxt_s = pend_r;
        if (expire_s) begin
            pend_nxt_s = 1'b1;
        end else if (ctrl_wr_s || preset_wr_s) begin
            pend_nxt_s = 1'b0;
        end else if ((state_r == S_INT) && auto_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // Control register: a CPU write overrides the one-shot auto-clear of EN.
    always_comb begin
        ctrl_nxt_s = ctrl_r;
        if (ctrl_wr_s) begin
            ctrl_nxt_s = DIN[3:0];
        end else if ((state_r == S_INT) && !auto_s) begin
            ctrl_nxt_s = {ctrl_r[3:1], 1'b0};
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
    end

    // Register file, countdown FSM and registered interrupt output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            ctrl_r   <= 4'd0;
            preset_r <= 32'd0;
            count_r  <= 32'd0;
            pend_r   <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            ctrl_r <= ctrl_nxt_s;
            pend_r <= pend_nxt_s;
            irq_r  <= ctrl_nxt_s[3] & pend_nxt_s;
            if (preset_wr_s) begin
                preset_r <= DIN;
            end
            case (state_r)
                S_IDLE: begin
                    if (en_s) begin
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_r <= preset_r;
                    state_r <= S_CNT;
                end
                S_CNT: begin
                    if (!en_s) begin
                        state_r <= S_IDLE;
                    end else if (count_r > 32'd1) begin
                        count_r <= count_r - 32'd1;
                    end else begin
                        count_r <= 32'd0;
                        state_r <= S_INT;
                    end
                end
                S_INT: begin
                    if (auto_s && en_s) begin
                        state_r <= S_LOAD;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational read mux over the register window.
    always_comb begin
        DOUT = 32'd0;
        case (Addr)
            2'd0:    DOUT = {28'd0, ctrl_r};
            2'd1:    DOUT = preset_r;
            2'd2:    DOUT = count_r;
            default: DOUT = 32'd0;
        endcase
    end

    assign IRQ = irq_r;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus a randomized run,
// all compared against a phase-based behavioural model of the timer.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;

    int compared   = 0;
    int mismatched = 0;

    timer_dev dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .DIN  (DIN),
        .DOUT (DOUT),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase -1 idle, 0 loading, 1..L counting (L = max(n,1)), -2 expired.
    localparam int P_IDLE = -1;
    localparam int P_INT  = -2;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic [31:0] m_n;
    logic        m_pend;
    int          m_phase;

    task automatic m_reset();
        m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
        m_n = 32'd0; m_pend = 1'b0; m_phase = P_IDLE;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input logic we, input logic [1:0] a, input logic [31:0] din);
        logic        en;
        logic        auto_m;
        logic        set;
        longint      len;
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset;
        logic [31:0] n_count;
        logic [31:0] n_n;
        logic        n_pend;
        int          n_phase;
        en = m_ctrl[0];
        auto_m = (m_ctrl[2:1] == 2'b01);
        set = 1'b0;
        n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
        n_n = m_n; n_pend = m_pend; n_phase = m_phase;
        len = (m_n == 32'd0) ? 64'd1 : longint'(m_n);
        if (m_phase == P_IDLE) begin
            if (en) n_phase = 0;
        end else if (m_phase == 0) begin
            n_n = m_preset; n_count = m_preset; n_phase = 1;
        end else if (m_phase == P_INT) begin
            if (auto_m) n_pend = 1'b0;
            if (auto_m && en) n_phase = 0;
            else n_phase = P_IDLE;
            if (!auto_m) n_ctrl[0] = 1'b0;
        end else begin
            if (!en) n_phase = P_IDLE;
            else if (longint'(m_phase) >= len) begin
                n_phase = P_INT; n_count = 32'd0; set = 1'b1;
            end else begin
                n_phase = m_phase + 1;
                n_count = m_n - 32'(m_phase);
            end
        end
        if (we && a == 2'd0) begin
            n_ctrl = din[3:0];
            n_pend = 1'b0;
        end
        if (we && a == 2'd1) begin
            n_preset = din;
            n_pend = 1'b0;
        end
        if (set) n_pend = 1'b1;
        m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
        m_n = n_n; m_pend = n_pend; m_phase = n_phase;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            check($sformatf("%s.dout%0d", tag, a), DOUT, m_read(2'(a)));
        end
        check($sformatf("%s.irq", tag), {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_pend});
    endtask

    task automatic exp_read(input string tag, input logic [1:0] a, input logic [31:0] val);
        Addr = a;
        #1;
        check(tag, DOUT, val);
    endtask

    task automatic exp_irq(input string tag, input logic val);
        check(tag, {31'd0, IRQ}, {31'd0, val});
    endtask

    task automatic tick(input logic we, input logic [1:0] a, input logic [31:0] din, input string tag);
        WE = we; Addr = a; DIN = din;
        @(posedge clk);
        m_step(we, a, din);
        #1;
        WE = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        m_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0, 2'd0, 32'd0, {tag, ".post"});
    endtask

    initial begin
        reset = 1'b0; WE = 1'b0; Addr = 2'd0; DIN = 32'd0;
        m_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0, 2'd0, 32'd0, "idle0");

        // One-shot, PRESET=5, IM set.
        tick(1'b1, 2'd1, 32'd5, "os.preset");
        tick(1'b1, 2'd0, 32'h9, "os.ctrl");
        tick(1'b0, 2'd0, 32'd0, "os.load");
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 2'd0, 32'd0, "os.cnt");
            exp_read($sformatf("os.count%0d", i), 2'd2, 32'(5 - i));
        end
        exp_irq("os.irq_rise", 1'b1);
        tick(1'b0, 2'd0, 32'd0, "os.int");
        exp_read("os.ctrl_en_clr", 2'd0, 32'h8);
        exp_irq("os.irq_hold", 1'b1);
        tick(1'b0, 2'd0, 32'd0, "os.hold1");
        tick(1'b0, 2'd0, 32'd0, "os.hold2");
        exp_irq("os.irq_hold2", 1'b1);
        tick(1'b1, 2'd1, 32'd7, "os.clr");
        exp_irq("os.irq_clr", 1'b0);

        // Auto-reload, PRESET=3 then 1 mid-count.
        tick(1'b1, 2'd1, 32'd3, "ar.preset");
        tick(1'b1, 2'd0, 32'hB, "ar.ctrl");
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 2'd0, 32'd0, "ar.run");
            exp_irq($sformatf("ar.irq%0d", k), (k % 5) == 0);
        end
        for (int k = 21; k <= 32; k++) begin
            if (k == 22) tick(1'b1, 2'd1, 32'd1, "ar.newpreset");
            else tick(1'b0, 2'd0, 32'd0, "ar.run2");
            exp_irq($sformatf("ar.irq%0d", k), (k == 25) || (k == 28) || (k == 31));
        end
        tick(1'b1, 2'd0, 32'd0, "ar.stop");
        tick(1'b0, 2'd0, 32'd0, "ar.stop1");
        tick(1'b0, 2'd0, 32'd0, "ar.stop2");

        // Auto-reload with IM=0, then IM set mid-period.
        tick(1'b1, 2'd1, 32'd4, "im.preset");
        tick(1'b1, 2'd0, 32'h3, "im.ctrl");
        for (int k = 1; k <= 14; k++) begin
            if (k == 9) tick(1'b1, 2'd0, 32'hB, "im.setim");
            else tick(1'b0, 2'd0, 32'd0, "im.run");
            exp_irq($sformatf("im.irq%0d", k), k == 12);
        end
        tick(1'b1, 2'd0, 32'd0, "im.stop");
        tick(1'b0, 2'd0, 32'd0, "im.stop1");
        tick(1'b0, 2'd0, 32'd0, "im.stop2");

        // EN cleared mid-count, re-enable, then reset mid-count.
        tick(1'b1, 2'd1, 32'd10, "fz.preset");
        tick(1'b1, 2'd0, 32'h9, "fz.ctrl");
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) tick(1'b1, 2'd0, 32'h8, "fz.clr_en");
            else tick(1'b0, 2'd0, 32'd0, "fz.run");
            if (k == 2) exp_read("fz.count10", 2'd2, 32'd10);
        end
        exp_read("fz.count6", 2'd2, 32'd6);
        tick(1'b0, 2'd0, 32'd0, "fz.idle1");
        exp_read("fz.hold6a", 2'd2, 32'd6);
        tick(1'b0, 2'd0, 32'd0, "fz.idle2");
        exp_read("fz.hold6b", 2'd2, 32'd6);
        tick(1'b1, 2'd0, 32'h9, "fz.reen");
        tick(1'b0, 2'd0, 32'd0, "fz.load");
        tick(1'b0, 2'd0, 32'd0, "fz.cnt");
        exp_read("fz.reload10", 2'd2, 32'd10);
        tick(1'b0, 2'd0, 32'd0, "fz.run2");
        tick(1'b0, 2'd0, 32'd0, "fz.run3");
        do_reset("fz.rst");
        exp_read("rst.count", 2'd2, 32'd0);
        exp_read("rst.preset", 2'd1, 32'd0);
        exp_read("rst.ctrl", 2'd0, 32'd0);
        exp_irq("rst.irq", 1'b0);

        // Ignored writes and PRESET=0.
        tick(1'b1, 2'd2, $urandom, "ro.count");
        exp_read("ro.count0", 2'd2, 32'd0);
        tick(1'b1, 2'd3, $urandom, "ro.resv");
        exp_read("ro.resv0", 2'd3, 32'd0);
        tick(1'b1, 2'd0, 32'hFFFF_FFF0, "ro.ctrlhi");
        exp_read("ro.ctrlhi0", 2'd0, 32'd0);
        tick(1'b1, 2'd1, 32'd0, "z.preset");
        tick(1'b1, 2'd0, 32'h9, "z.ctrl");
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 2'd0, 32'd0, "z.run");
            exp_irq($sformatf("z.irq%0d", k), k >= 3);
        end
        tick(1'b1, 2'd0, 32'd0, "z.stop");

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 199);
            d = $urandom;
            if (r < 14) begin
                tick(1'b1, 2'd1, 32'($urandom_range(0, 6)), "rnd.preset");
            end else if (r < 24) begin
                if ($urandom_range(0, 9) < 7) d[0] = 1'b1;
                tick(1'b1, 2'd0, d, "rnd.ctrl");
            end else if (r < 28) begin
                tick(1'b1, 2'($urandom_range(2, 3)), d, "rnd.ro");
            end else if (r == 199) begin
                do_reset("rnd.rst");
            end else begin
                tick(1'b0, 2'($urandom_range(0, 3)), d, "rnd.idle");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
